alu_ctrl_seq: RTL and testbench
===============================

// Module: alu_ctrl_seq
// PURPOSE
//  Registered, handshaked successor to the combinational ALU-op decoder. Decodes ALUOp/Funct3/Funct7
//  into an OP_W-bit ALU operation code and adds RV32M (MUL/DIV/REM) with multi-cycle sequencing.
//  Sits between the main Controller's decode stage and the ALU/muldiv datapath in EX.
//  Valid/ready on both sides; flags illegal encodings.
// PARAMETERS
//  OP_W     5   Operation width; >=5; bits above [4] driven 0
//  MUL_LAT  2   cycles from accept to out_valid for MUL/MULH/MULHSU/MULHU; >=2
//  DIV_LAT  32  cycles from accept to out_valid for DIV/DIVU/REM/REMU; >=2
// PORTS
//  clk        in   1     clock, rising edge
//  rst_n      in   1     asynchronous reset, active low
//  in_valid   in   1     decode fields valid
//  in_ready   out  1     block can accept
//  ALUOp      in   2     00 LW/SW/AUIPC, 01 branch, 10 R/I-type ALU, 11 JAL/LUI
//  IsRType    in   1     1 = R-type; enables SUB/SRA-by-funct7 and M-ext decode
//  Funct7     in   7     instr[31:25]
//  Funct3     in   3     instr[14:12]
//  flush      in   1     synchronous pipeline flush
//  out_valid  out  1     Operation/flags valid
//  out_ready  in   1     EX consumes result
//  Operation  out  OP_W  ALU operation code
//  multi_cycle out 1     registered op is M-ext
//  busy       out  1     M-ext op in progress (EXEC)
//  illegal    out  1     registered op was illegal encoding
// BEHAVIOUR
//  Codes: AND 00000, OR 00001, ADD 00010, XOR 00011, SLL 00100, SRL 00101, SUB 00110, SRA 00111,
//   branch {2'b01,Funct3}, M-ext {2'b10,Funct3}, SLT 11000, SLTU 11001.
//  ALUOp 00 and 11 -> ADD. ALUOp 01 -> branch code; Funct3 010/011 illegal.
//  ALUOp 10: f3 000 ADD (SUB if IsRType & f7=0100000); 001 SLL; 010 SLT; 011 SLTU; 100 XOR;
//   101 SRL (f7=0000000) / SRA (f7=0100000), other f7 illegal; 110 OR; 111 AND.
//   IsRType & f7=0000001 -> M-ext; IsRType & f7 not in {0000000,0100000,0000001} -> illegal;
//   IsRType & f7=0100000 with f3 not in {000,101} -> illegal.
//  Illegal: Operation=00000, illegal=1, treated as single-cycle.
//  FSM IDLE/EXEC/VALID. in_ready = !flush & (IDLE | (VALID & out_ready)). Accept = in_valid & in_ready.
//  Accept: Operation, multi_cycle, illegal registered at that edge, held stable until out handshake.
//   Single-cycle -> VALID (out_valid next cycle, latency 1).
//   M-ext -> EXEC, cnt loaded LAT-2; busy=1; EXEC->VALID when cnt==0; out_valid exactly LAT cycles after accept.
//  VALID: out_valid=1 until out_ready; handshake w/ accept -> back-to-back (new op, no bubble);
//   handshake w/o accept -> IDLE. out_valid never drops without out_ready or flush.
//  flush (highest priority, any state): next state IDLE, cnt=0, out_valid/busy/multi_cycle/illegal=0,
//   Operation=0; concurrent in_valid dropped.
//  Reset (async, any state incl. mid-EXEC): state IDLE, cnt 0, all outputs 0 except in_ready=1
//   (combinational from IDLE) once rst_n high.
//  cnt width $clog2(max(MUL_LAT,DIV_LAT)); no wrap: only decrements in EXEC, stops at 0.
// CONFIGURATION
//  ALU_CTRL_PERF_EN defined: extra outputs perf_ops[31:0] (out handshakes) and perf_stall[31:0]
//   (cycles busy=1); reset/flush-independent, cleared only by rst_n, wrap at 2^32.
//  Undefined: ports and counters absent; behaviour otherwise identical.
// TESTING
//  ALUOp=10,f3=000,IsRType=1,f7=0100000, out_ready=1 -> next cycle out_valid=1, Operation=00110.
//  ALUOp=10,f3=000,IsRType=0,f7=0100000 (ADDI neg imm) -> Operation=00010, illegal=0.
//  MUL (f7=0000001,f3=000) accept at cycle 0 -> busy cycles 1..1, out_valid at cycle 2, Op=10000;
//   DIVU f3=101 -> out_valid at cycle 32, Op=10101, in_ready=0 meanwhile.
//  Stream 4 ALU ops, out_ready=1 -> one out_valid per cycle; out_ready=0 for 3 cycles -> Operation held.
//  flush at cycle 10 of DIV -> cycle 11 IDLE, busy=0, out_valid=0; rst_n low mid-EXEC -> same, in_ready=1 after.
//  ALUOp=10,f3=101,f7=0010000 -> illegal=1, Operation=00000; ALUOp=01,f3=010 -> illegal=1.

Source files
------------

// File: rtl/alu_ctrl_seq_if.sv
// Decode-to-EX handshake bundle for alu_ctrl_seq: decode fields in, operation code and status out.
interface alu_ctrl_seq_if #(parameter int OP_W = 5);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      ALUOp;
  logic            IsRType;
  logic [6:0]      Funct7;
  logic [2:0]      Funct3;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [OP_W-1:0] Operation;
  logic            multi_cycle;
  logic            busy;
  logic            illegal;

  modport master (
    output in_valid, ALUOp, IsRType, Funct7, Funct3, flush, out_ready,
    input  in_ready, out_valid, Operation, multi_cycle, busy, illegal
  );

  modport slave (
    input  in_valid, ALUOp, IsRType, Funct7, Funct3, flush, out_ready,
    output in_ready, out_valid, Operation, multi_cycle, busy, illegal
  );
endinterface

// File: rtl/alu_ctrl_seq.sv
// Registered ALU-op decoder with RV32M multi-cycle sequencing and valid/ready on both sides.
// Optional performance counters are built when ALU_CTRL_PERF_EN is defined.
module alu_ctrl_seq #(
  parameter int OP_W    = 5,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_ctrl_seq_if.slave bus
`ifdef ALU_CTRL_PERF_EN
  ,
  output logic [31:0]   perf_ops,
  output logic [31:0]   perf_stall
`endif
);
  localparam int LAT_MAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(LAT_MAX);
  localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_LAT - 2);
  localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_LAT - 2);

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

  typedef enum logic [1:0] {IDLE, EXEC, VALID} state_t;

  state_t          state;
  logic [CNT_W-1:0] cnt;
  logic            out_valid_q, busy_q, mc_q, ill_q;
  logic [OP_W-1:0] op_q;

  logic [4:0]      dec_op;
  logic            dec_mc, dec_ill;
  logic [OP_W-1:0] op_full;
  logic            accept;

  always_comb begin
    dec_op  = 5'b00010;
    dec_mc  = 1'b0;
    dec_ill = 1'b0;
    case (bus.ALUOp)
      2'b01: begin
        if (bus.Funct3 == 3'b010 || bus.Funct3 == 3'b011) dec_ill = 1'b1;
        else dec_op = {2'b01, bus.Funct3};
      end
      2'b10: begin
        if (bus.IsRType && bus.Funct7 == F7_MEXT) begin
          dec_op = {2'b10, bus.Funct3};
          dec_mc = 1'b1;
        end else if (bus.IsRType && bus.Funct7 != F7_BASE && bus.Funct7 != F7_ALT) begin
          dec_ill = 1'b1;
        end else if (bus.IsRType && bus.Funct7 == F7_ALT &&
                     bus.Funct3 != 3'b000 && bus.Funct3 != 3'b101) begin
          dec_ill = 1'b1;
        end else begin
          case (bus.Funct3)
            3'b000: dec_op = (bus.IsRType && bus.Funct7 == F7_ALT) ? 5'b00110 : 5'b00010;
            3'b001: dec_op = 5'b00100;
            3'b010: dec_op = 5'b11000;
            3'b011: dec_op = 5'b11001;
            3'b100: dec_op = 5'b00011;
            // Shift-right type comes from funct7 even for immediates (SRLI/SRAI)
            3'b101: begin
              if (bus.Funct7 == F7_BASE)     dec_op  = 5'b00101;
              else if (bus.Funct7 == F7_ALT) dec_op  = 5'b00111;
              else                           dec_ill = 1'b1;
            end
            3'b110: dec_op = 5'b00001;
            default: dec_op = 5'b00000;
          endcase
        end
      end
      default: dec_op = 5'b00010;
    endcase
    if (dec_ill) dec_op = 5'b00000;
  end

  always_comb begin
    op_full      = '0;
    op_full[4:0] = dec_op;
  end

  assign bus.in_ready = !bus.flush &&
                        (state == IDLE || (state == VALID && bus.out_ready));
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      mc_q        <= 1'b0;
      ill_q       <= 1'b0;
      op_q        <= '0;
    end else if (bus.flush) begin
      state       <= IDLE;
      cnt         <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      mc_q        <= 1'b0;
      ill_q       <= 1'b0;
      op_q        <= '0;
    end else if (accept) begin
      // Covers both IDLE and back-to-back VALID handoff
      op_q  <= op_full;
      mc_q  <= dec_mc;
      ill_q <= dec_ill;
      if (dec_mc) begin
        state       <= EXEC;
        cnt         <= bus.Funct3[2] ? DIV_LD : MUL_LD;
        busy_q      <= 1'b1;
        out_valid_q <= 1'b0;
      end else begin
        state       <= VALID;
        busy_q      <= 1'b0;
        out_valid_q <= 1'b1;
      end
    end else begin
      case (state)
        EXEC: begin
          if (cnt == '0) begin
            state       <= VALID;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        VALID: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.busy        = busy_q;
  assign bus.multi_cycle = mc_q;
  assign bus.illegal     = ill_q;
  assign bus.Operation   = op_q;

`ifdef ALU_CTRL_PERF_EN
  // Free-running statistics; only rst_n clears them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_ops   <= '0;
      perf_stall <= '0;
    end else begin
      if (out_valid_q && bus.out_ready) perf_ops <= perf_ops + 32'd1;
      if (busy_q) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq: decode table, hand-built corner sequences, random traffic vs a timing model.
module tb_alu_ctrl_seq;
  localparam int OP_W    = 5;
  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_ctrl_seq_if #(.OP_W(OP_W)) bus();
`ifdef ALU_CTRL_PERF_EN
  logic [31:0] perf_ops, perf_stall;
`endif

  alu_ctrl_seq #(.OP_W(OP_W), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
`ifdef ALU_CTRL_PERF_EN
    ,
    .perf_ops(perf_ops),
    .perf_stall(perf_stall)
`endif
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic drive(input bit v, input logic [1:0] a, input bit r,
                       input logic [6:0] f7, input logic [2:0] f3);
    bus.in_valid = v;
    bus.ALUOp    = a;
    bus.IsRType  = r;
    bus.Funct7   = f7;
    bus.Funct3   = f3;
  endtask

  // Reference decode straight from the opcode rules; latency is accept-to-valid in cycles
  function automatic void ref_dec(input logic [1:0] a, input bit r, input logic [6:0] f7,
                                  input logic [2:0] f3, output logic [4:0] op,
                                  output bit ill, output bit mc, output int lat);
    bit alt;
    ill = 1'b0; mc = 1'b0; op = 5'd2; lat = 1;
    alt = (f7 == 7'h20);
    if (a == 2'b01) begin
      if (f3 == 3'd2 || f3 == 3'd3) ill = 1'b1;
      else op = {2'b01, f3};
    end else if (a == 2'b10) begin
      if (r && f7 == 7'h01) begin
        mc = 1'b1; op = {2'b10, f3};
        lat = (f3 >= 3'd4) ? DIV_LAT : MUL_LAT;
      end else if (r && !(f7 == 7'h00 || alt)) ill = 1'b1;
      else if (r && alt && !(f3 == 3'd0 || f3 == 3'd5)) ill = 1'b1;
      else begin
        case (f3)
          3'd0: op = (r && alt) ? 5'd6 : 5'd2;
          3'd1: op = 5'd4;
          3'd2: op = 5'd24;
          3'd3: op = 5'd25;
          3'd4: op = 5'd3;
          3'd5: begin
            if (f7 == 7'h00) op = 5'd5;
            else if (alt)    op = 5'd7;
            else             ill = 1'b1;
          end
          3'd6: op = 5'd1;
          default: op = 5'd0;
        endcase
      end
    end
    if (ill) op = 5'd0;
  endfunction

  typedef struct {
    logic [1:0] a;
    bit         r;
    logic [6:0] f7;
    logic [2:0] f3;
    logic [4:0] op;
    bit         ill;
    bit         mc;
    int         lat;
  } vec_t;

  vec_t vt[16];

  bit         have;
  int         due, cyc, n;
  logic [4:0] m_op;
  bit         m_ill, m_mc, got_v;
  bit         exp_v, exp_rdy, exp_busy;
  logic [4:0] s_exp[4];

  initial begin
    vt[0]  = '{2'b10, 1'b1, 7'h20, 3'b000, 5'b00110, 1'b0, 1'b0, 1};        // SUB
    vt[1]  = '{2'b10, 1'b0, 7'h20, 3'b000, 5'b00010, 1'b0, 1'b0, 1};        // ADDI neg imm
    vt[2]  = '{2'b10, 1'b1, 7'h01, 3'b000, 5'b10000, 1'b0, 1'b1, MUL_LAT};  // MUL
    vt[3]  = '{2'b10, 1'b1, 7'h01, 3'b101, 5'b10101, 1'b0, 1'b1, DIV_LAT};  // DIVU
    vt[4]  = '{2'b10, 1'b0, 7'h10, 3'b101, 5'b00000, 1'b1, 1'b0, 1};        // bad shift f7
    vt[5]  = '{2'b01, 1'b0, 7'h00, 3'b010, 5'b00000, 1'b1, 1'b0, 1};        // bad branch
    vt[6]  = '{2'b01, 1'b0, 7'h00, 3'b101, 5'b01101, 1'b0, 1'b0, 1};        // BGE
    vt[7]  = '{2'b00, 1'b1, 7'h55, 3'b111, 5'b00010, 1'b0, 1'b0, 1};        // LW/SW
    vt[8]  = '{2'b11, 1'b0, 7'h00, 3'b011, 5'b00010, 1'b0, 1'b0, 1};        // JAL/LUI
    vt[9]  = '{2'b10, 1'b1, 7'h20, 3'b101, 5'b00111, 1'b0, 1'b0, 1};        // SRA
    vt[10] = '{2'b10, 1'b0, 7'h00, 3'b011, 5'b11001, 1'b0, 1'b0, 1};        // SLTIU
    vt[11] = '{2'b10, 1'b1, 7'h00, 3'b010, 5'b11000, 1'b0, 1'b0, 1};        // SLT
    vt[12] = '{2'b10, 1'b1, 7'h20, 3'b001, 5'b00000, 1'b1, 1'b0, 1};        // f7 alt, f3 001
    vt[13] = '{2'b10, 1'b1, 7'h02, 3'b110, 5'b00000, 1'b1, 1'b0, 1};        // unknown R f7
    vt[14] = '{2'b10, 1'b0, 7'h7f, 3'b001, 5'b00100, 1'b0, 1'b0, 1};        // SLLI, f7 ignored
    vt[15] = '{2'b10, 1'b1, 7'h01, 3'b011, 5'b10011, 1'b0, 1'b1, MUL_LAT};  // MULHU

    drive(1'b0, 2'b00, 1'b0, 7'h00, 3'b000);
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_illegal", 32'(bus.illegal), 32'd0);
    check("rst_multi_cycle", 32'(bus.multi_cycle), 32'd0);
    check("rst_operation", 32'(bus.Operation), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Decode table, one isolated transaction each
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      drive(1'b1, vt[i].a, vt[i].r, vt[i].f7, vt[i].f3);
      bus.out_ready = 1'b1;
      @(negedge clk);
      check($sformatf("vec%0d_in_ready", i), 32'(bus.in_ready), 32'd1);
      @(posedge clk); #1 bus.in_valid = 1'b0;
      n = 1; got_v = 1'b0;
      while (n < 100) begin
        @(negedge clk);
        if (bus.out_valid) begin got_v = 1'b1; break; end
        if (vt[i].mc) begin
          check($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'd1);
          check($sformatf("vec%0d_exec_in_ready", i), 32'(bus.in_ready), 32'd0);
        end
        n++;
      end
      check($sformatf("vec%0d_seen", i), 32'(got_v), 32'd1);
      check($sformatf("vec%0d_latency", i), 32'(n), 32'(vt[i].lat));
      check($sformatf("vec%0d_op", i), 32'(bus.Operation), 32'(vt[i].op));
      check($sformatf("vec%0d_illegal", i), 32'(bus.illegal), 32'(vt[i].ill));
      check($sformatf("vec%0d_mc", i), 32'(bus.multi_cycle), 32'(vt[i].mc));
      check($sformatf("vec%0d_busy_done", i), 32'(bus.busy), 32'd0);
    end
    @(posedge clk); #1 bus.out_ready = 1'b0;

    // Back-to-back stream of ALU ops, then stall
    s_exp[0] = 5'd2; s_exp[1] = 5'd3; s_exp[2] = 5'd1; s_exp[3] = 5'd4;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      case (k)
        0: drive(1'b1, 2'b10, 1'b0, 7'h00, 3'b000);
        1: drive(1'b1, 2'b10, 1'b0, 7'h00, 3'b100);
        2: drive(1'b1, 2'b10, 1'b0, 7'h00, 3'b110);
        default: drive(1'b1, 2'b10, 1'b0, 7'h00, 3'b001);
      endcase
      bus.out_ready = 1'b1;
      @(negedge clk);
      check($sformatf("stream%0d_in_ready", k), 32'(bus.in_ready), 32'd1);
      if (k > 0) begin
        check($sformatf("stream%0d_out_valid", k), 32'(bus.out_valid), 32'd1);
        check($sformatf("stream%0d_op", k), 32'(bus.Operation), 32'(s_exp[k-1]));
      end
    end
    @(posedge clk); #1 bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_out_valid", 32'(bus.out_valid), 32'd1);
      check("stall_op_held", 32'(bus.Operation), 32'(s_exp[3]));
      check("stall_in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1 bus.out_ready = 1'b0;
    @(negedge clk);
    check("drain_out_valid", 32'(bus.out_valid), 32'd0);

    // Flush at cycle 10 of a DIV
    @(posedge clk); #1 drive(1'b1, 2'b10, 1'b1, 7'h01, 3'b100);
    @(posedge clk); #1 bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(negedge clk);
    check("flush_pre_busy", 32'(bus.busy), 32'd1);
    @(posedge clk); #1 bus.flush = 1'b0;
    @(negedge clk);
    check("flush_busy", 32'(bus.busy), 32'd0);
    check("flush_out_valid", 32'(bus.out_valid), 32'd0);
    check("flush_in_ready", 32'(bus.in_ready), 32'd1);
    check("flush_mc", 32'(bus.multi_cycle), 32'd0);
    check("flush_op", 32'(bus.Operation), 32'd0);
    repeat (40) @(negedge clk);
    check("flush_no_late_valid", 32'(bus.out_valid), 32'd0);

    // Flush drops a concurrent request
    @(posedge clk); #1 drive(1'b1, 2'b10, 1'b0, 7'h00, 3'b100); bus.flush = 1'b1;
    @(negedge clk);
    check("flush_drop_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1 bus.in_valid = 1'b0; bus.flush = 1'b0;
    @(negedge clk);
    check("flush_drop_out_valid", 32'(bus.out_valid), 32'd0);

    // Async reset in the middle of EXEC
    @(posedge clk); #1 drive(1'b1, 2'b10, 1'b1, 7'h01, 3'b110);
    @(posedge clk); #1 bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_mc", 32'(bus.multi_cycle), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("arst_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (40) @(negedge clk);
    check("arst_no_late_valid", 32'(bus.out_valid), 32'd0);

    // Random traffic against a time-based model of the pending op
    have = 1'b0; due = 0; cyc = 0; m_op = '0; m_ill = 1'b0; m_mc = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      bus.in_valid = ($urandom_range(0, 1) == 1);
      bus.ALUOp    = 2'($urandom_range(0, 3));
      bus.IsRType  = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 3))
        0: bus.Funct7 = 7'h00;
        1: bus.Funct7 = 7'h20;
        2: bus.Funct7 = 7'h01;
        default: bus.Funct7 = 7'($urandom_range(0, 127));
      endcase
      bus.Funct3    = 3'($urandom_range(0, 7));
      bus.out_ready = ($urandom_range(0, 9) < 7);
      bus.flush     = ($urandom_range(0, 99) < 3);
      @(negedge clk);
      exp_v    = have && (cyc >= due);
      exp_rdy  = !bus.flush && (!have || (exp_v && bus.out_ready));
      exp_busy = have && m_mc && (cyc < due);
      check("rnd_out_valid", 32'(bus.out_valid), 32'(exp_v));
      check("rnd_in_ready", 32'(bus.in_ready), 32'(exp_rdy));
      check("rnd_busy", 32'(bus.busy), 32'(exp_busy));
      if (exp_v) begin
        check("rnd_op", 32'(bus.Operation), 32'(m_op));
        check("rnd_illegal", 32'(bus.illegal), 32'(m_ill));
        check("rnd_mc", 32'(bus.multi_cycle), 32'(m_mc));
      end
      if (bus.flush) have = 1'b0;
      else begin
        if (exp_v && bus.out_ready) have = 1'b0;
        if (bus.in_valid && exp_rdy) begin
          int lat;
          ref_dec(bus.ALUOp, bus.IsRType, bus.Funct7, bus.Funct3, m_op, m_ill, m_mc, lat);
          have = 1'b1;
          due  = cyc + lat;
        end
      end
      cyc++;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
